// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module : keypad_pkg
// Brief  : Key codes, entry states and number format shared by the keypad path
// Rev    : 1.0
// ============================================================================
package keypad_pkg;

  localparam int VALUE_W = 25;

  localparam logic [3:0] KEY_DP    = 4'd10;
  localparam logic [3:0] KEY_MINUS = 4'd11;
  localparam logic [3:0] KEY_ENTER = 4'd12;
  localparam logic [3:0] KEY_CLEAR = 4'd13;

  // Display glyph codes understood by the display formatter
  localparam logic [3:0] DISP_BLANK = 4'd10;
  localparam logic [3:0] DISP_MINUS = 4'd11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_INT   = 2'd1,
    ST_FRAC  = 2'd2,
    ST_DONE  = 2'd3
  } entry_state_t;

endpackage
`default_nettype wire

// File: rtl/entry_accum.sv
`default_nettype none
// ============================================================================
// Module : entry_accum
// Brief  : Next-value datapath: integer append (x10 + d*1000), fraction add (d*W)
// Rev    : 1.0
// ============================================================================
module entry_accum
  import keypad_pkg::*;
(
  input  logic [VALUE_W-1:0] i_value,
  input  logic [3:0]         i_digit,
  input  logic [1:0]         i_frac_cnt,
  output logic [VALUE_W-1:0] o_int_value,
  output logic [VALUE_W-1:0] o_frac_value
);

  localparam int c_wide_w = VALUE_W + 4;

  logic [c_wide_w-1:0] w_value_wide;
  logic [c_wide_w-1:0] w_digit_wide;
  logic [c_wide_w-1:0] w_x10;
  logic [c_wide_w-1:0] w_digit_k;
  logic [VALUE_W-1:0]  w_digit_v;
  logic [VALUE_W-1:0]  w_frac_inc;

  assign w_value_wide = c_wide_w'(i_value);
  assign w_digit_wide = c_wide_w'(i_digit);
  assign w_x10        = (w_value_wide << 3) + (w_value_wide << 1);
  // 1000 = 1024 - 16 - 8
  assign w_digit_k    = (w_digit_wide << 10) - (w_digit_wide << 4) - (w_digit_wide << 3);
  assign o_int_value  = VALUE_W'(w_x10 + w_digit_k);

  assign w_digit_v = VALUE_W'(i_digit);

  always_comb begin
    w_frac_inc = '0;
    case (i_frac_cnt)
      2'd0:    w_frac_inc = (w_digit_v << 6) + (w_digit_v << 5) + (w_digit_v << 2);
      2'd1:    w_frac_inc = (w_digit_v << 3) + (w_digit_v << 1);
      2'd2:    w_frac_inc = w_digit_v;
      default: w_frac_inc = '0;
    endcase
  end

  assign o_frac_value = i_value + w_frac_inc;

endmodule
`default_nettype wire

// File: rtl/keypad_number_entry.sv
`default_nettype none
// ============================================================================
// Module : keypad_number_entry
// Brief  : Builds a signed thousandths fixed-point operand from keypad codes
// Rev    : 1.0
// ============================================================================
module keypad_number_entry
  import keypad_pkg::*;
#(
  parameter int INT_MAX_POS = 4,
  parameter int INT_MAX_NEG = 3,
  parameter int FRAC_MAX    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [3:0]         key_code,
  output logic [VALUE_W-1:0] value,
  output logic               neg,
  output logic [2:0]         int_cnt,
  output logic [1:0]         frac_cnt,
  output logic               entry_done,
  output logic               valid,
  output logic               err
);

  localparam logic [2:0] c_lim_pos  = 3'(INT_MAX_POS);
  localparam logic [2:0] c_lim_neg  = 3'(INT_MAX_NEG);
  localparam logic [1:0] c_frac_lim = 2'(FRAC_MAX);

  entry_state_t       r_state, w_state_nxt, w_base_state;
  logic [VALUE_W-1:0] r_value, w_value_nxt, w_base_value;
  logic               r_neg, w_neg_nxt, w_base_neg;
  logic [2:0]         r_int_cnt, w_int_cnt_nxt, w_base_int_cnt;
  logic [1:0]         r_frac_cnt, w_frac_cnt_nxt, w_base_frac_cnt;
  logic               r_valid, w_valid_nxt;
  logic               r_err, w_err_nxt;

  logic               w_restart;
  logic [2:0]         w_limit;
  logic [VALUE_W-1:0] w_int_value;
  logic [VALUE_W-1:0] w_frac_value;

  // A new key after a finished entry starts over from an empty entry in the same cycle
  assign w_restart = (r_state == ST_DONE) && key_valid &&
                     (key_code != KEY_CLEAR) && (key_code != KEY_ENTER);

  assign w_base_state    = w_restart ? ST_EMPTY : r_state;
  assign w_base_value    = w_restart ? '0 : r_value;
  assign w_base_neg      = w_restart ? 1'b0 : r_neg;
  assign w_base_int_cnt  = w_restart ? 3'd0 : r_int_cnt;
  assign w_base_frac_cnt = w_restart ? 2'd0 : r_frac_cnt;
  assign w_limit         = w_base_neg ? c_lim_neg : c_lim_pos;

  entry_accum u_accum (
    .i_value      (w_base_value),
    .i_digit      (key_code),
    .i_frac_cnt   (w_base_frac_cnt),
    .o_int_value  (w_int_value),
    .o_frac_value (w_frac_value)
  );

  always_comb begin
    w_state_nxt    = w_base_state;
    w_value_nxt    = w_base_value;
    w_neg_nxt      = w_base_neg;
    w_int_cnt_nxt  = w_base_int_cnt;
    w_frac_cnt_nxt = w_base_frac_cnt;
    w_valid_nxt    = 1'b0;
    w_err_nxt      = 1'b0;
    if (key_valid) begin
      if (key_code <= 4'd9) begin
        case (w_base_state)
          ST_EMPTY, ST_INT: begin
            if ((w_base_value == '0) && (key_code == 4'd0)) begin
              w_state_nxt = ST_INT;
            end else if (w_base_int_cnt < w_limit) begin
              w_value_nxt   = w_int_value;
              w_int_cnt_nxt = w_base_int_cnt + 3'd1;
              w_state_nxt   = ST_INT;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          ST_FRAC: begin
            if (w_base_frac_cnt < c_frac_lim) begin
              w_value_nxt    = w_frac_value;
              w_frac_cnt_nxt = w_base_frac_cnt + 2'd1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          default: w_err_nxt = 1'b1;
        endcase
      end else begin
        case (key_code)
          KEY_DP: begin
            if ((w_base_state == ST_EMPTY) || (w_base_state == ST_INT)) begin
              w_state_nxt = ST_FRAC;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          KEY_MINUS: begin
            if ((w_base_state == ST_EMPTY) && !w_base_neg) begin
              w_neg_nxt = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          KEY_ENTER: begin
            if ((w_base_state == ST_INT) || (w_base_state == ST_FRAC)) begin
              w_state_nxt = ST_DONE;
              w_valid_nxt = 1'b1;
              if (w_base_value == '0) begin
                w_neg_nxt = 1'b0;
              end
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          KEY_CLEAR: begin
            w_state_nxt    = ST_EMPTY;
            w_value_nxt    = '0;
            w_neg_nxt      = 1'b0;
            w_int_cnt_nxt  = 3'd0;
            w_frac_cnt_nxt = 2'd0;
          end
          default: w_err_nxt = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_value    <= '0;
      r_neg      <= 1'b0;
      r_int_cnt  <= 3'd0;
      r_frac_cnt <= 2'd0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_value    <= w_value_nxt;
      r_neg      <= w_neg_nxt;
      r_int_cnt  <= w_int_cnt_nxt;
      r_frac_cnt <= w_frac_cnt_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign value      = r_value;
  assign neg        = r_neg;
  assign int_cnt    = r_int_cnt;
  assign frac_cnt   = r_frac_cnt;
  assign entry_done = (r_state == ST_DONE);
  assign valid      = r_valid;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_keypad_number_entry.sv
`default_nettype none
// ============================================================================
// Module : tb_keypad_number_entry
// Brief  : Directed and random key sequences against a digit-list entry model
// Rev    : 1.0
// ============================================================================
module tb_keypad_number_entry;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [24:0] value;
  logic        neg;
  logic [2:0]  int_cnt;
  logic [1:0]  frac_cnt;
  logic        entry_done;
  logic        valid;
  logic        err;

  always #5 clk = ~clk;

  keypad_number_entry dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .value      (value),
    .neg        (neg),
    .int_cnt    (int_cnt),
    .frac_cnt   (frac_cnt),
    .entry_done (entry_done),
    .valid      (valid),
    .err        (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: integer part as a number, fraction as the digit string typed so far
  localparam int P_EMPTY = 0, P_INT = 1, P_FRAC = 2, P_DONE = 3;
  int     m_phase;
  longint m_int;
  int     m_frac;
  int     m_fc;
  bit     m_neg;
  bit     e_valid;
  bit     e_err;

  function automatic int ndigits(input longint v);
    int n = 0;
    while (v > 0) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_EMPTY;
    m_int   = 0;
    m_frac  = 0;
    m_fc    = 0;
    m_neg   = 1'b0;
    e_valid = 1'b0;
    e_err   = 1'b0;
  endtask

  task automatic model_key(input int code);
    int lim;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (m_phase == P_DONE && code != 13 && code != 12) begin
      m_phase = P_EMPTY; m_int = 0; m_frac = 0; m_fc = 0; m_neg = 1'b0;
    end
    lim = m_neg ? 3 : 4;
    if (code <= 9) begin
      if (m_phase == P_FRAC) begin
        if (m_fc < 3) begin
          m_frac = m_frac * 10 + code;
          m_fc++;
        end else e_err = 1'b1;
      end else if (m_int == 0 && code == 0) begin
        m_phase = P_INT;
      end else if (ndigits(m_int * 10 + code) <= lim) begin
        m_int   = m_int * 10 + code;
        m_phase = P_INT;
      end else e_err = 1'b1;
    end else if (code == 10) begin
      if (m_phase == P_FRAC) e_err = 1'b1;
      else m_phase = P_FRAC;
    end else if (code == 11) begin
      if (m_phase == P_EMPTY && !m_neg) m_neg = 1'b1;
      else e_err = 1'b1;
    end else if (code == 12) begin
      if (m_phase == P_INT || m_phase == P_FRAC) begin
        m_phase = P_DONE;
        e_valid = 1'b1;
        if (m_int == 0 && m_frac == 0) m_neg = 1'b0;
      end else e_err = 1'b1;
    end else if (code == 13) begin
      model_reset();
    end else begin
      e_err = 1'b1;
    end
  endtask

  task automatic check_all();
    longint exp_value;
    exp_value = m_int * 1000 + longint'(m_frac) * pow10(3 - m_fc);
    check("value", 32'(value), 32'(exp_value));
    check("neg", 32'(neg), 32'(m_neg));
    check("int_cnt", 32'(int_cnt), 32'(ndigits(m_int)));
    check("frac_cnt", 32'(frac_cnt), 32'(m_fc));
    check("entry_done", 32'(entry_done), 32'(m_phase == P_DONE));
    check("valid", 32'(valid), 32'(e_valid));
    check("err", 32'(err), 32'(e_err));
  endtask

  // Drive one cycle at the falling edge, then check after the rising edge
  task automatic step(input bit kv, input int code, input bit r);
    rst       = r;
    key_valid = kv;
    key_code  = 4'(code);
    if (r) model_reset();
    else if (kv) model_key(code);
    else begin
      e_valid = 1'b0;
      e_err   = 1'b0;
    end
    @(negedge clk);
    check_all();
    rst       = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic press(input int code);
    step(1'b1, code, 1'b0);
  endtask

  initial begin
    int u;
    int code;
    bit kv;
    bit r;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    model_reset();
    step(1'b0, 0, 1'b1);
    step(1'b1, 12, 1'b1);

    // 1,2,3,4,enter
    press(1); check("plan_v1", 32'(value), 32'd1000);
    press(2); check("plan_v12", 32'(value), 32'd12000);
    press(3); press(4); check("plan_v1234", 32'(value), 32'd1234000);
    press(12); check("plan_valid", 32'(valid), 32'd1);
    press(13);
    // -005.25
    press(11); press(0); press(0); press(5); press(10); press(2); press(5); press(12);
    check("plan_neg_val", 32'(value), 32'd5250);
    press(13);
    // -1234 overflow
    press(11); press(1); press(2); press(3); press(4);
    check("plan_neg_ovf", 32'(err), 32'd1);
    press(13);
    // .0078, extra DP, enter
    press(10); press(0); press(0); press(7); press(8); press(10); press(12);
    check("plan_frac_val", 32'(value), 32'd7);
    press(13);
    // -0 enter
    press(11); press(0); press(12);
    check("plan_negzero", 32'(neg), 32'd0);
    press(13);
    press(12);
    // 9,enter,3
    press(9); press(12); press(3);
    check("plan_restart", 32'(value), 32'd3000);
    press(13);
    // max positive and negative values
    for (int i = 0; i < 4; i++) press(9);
    press(10); for (int i = 0; i < 4; i++) press(9);
    press(12);
    press(11); for (int i = 0; i < 4; i++) press(9);
    press(10); for (int i = 0; i < 3; i++) press(9);
    press(12);
    // 5.1 then clear together with rst
    press(5); press(10); press(1);
    step(1'b1, 13, 1'b1);

    for (int n = 0; n < 4000; n++) begin
      r  = ($urandom_range(0, 149) == 0);
      kv = ($urandom_range(0, 9) < 8);
      u  = int'($urandom_range(0, 99));
      if (u < 55)      code = int'($urandom_range(0, 9));
      else if (u < 65) code = 10;
      else if (u < 72) code = 11;
      else if (u < 84) code = 12;
      else if (u < 89) code = 13;
      else if (u < 92) code = int'($urandom_range(14, 15));
      else             code = 0;
      step(kv, code, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
